nr_quotient_approx: RTL
=======================

# nr_quotient_approx

Sequential Newton-Raphson quotient approximator for the FPU divide path. It accepts two normalized significands, iterates a reciprocal of the divisor from a table seed, and forms the approximate quotient E and the back-product Eb = E·Db. It presents Da, Db, E, Eb and db to the final quotient selection and rounding-sticky stage. The block sits between significand unpacking and that selection stage, using one shared 58×58 multiply per cycle.

## Interface
- ITER_D, 3: Newton iterations for double precision (db=1).
- ITER_S, 2: Newton iterations for single precision (db=0).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- fa  in  53  dividend significand, 1.52 format, hidden bit fa[52]=1. In single mode the low 29 bits are zero.
- fb  in  53  divisor significand, same format.
- db_in  in  1  1 = double precision, 0 = single precision.
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- Da  out  58  {fa, 5'b0}, 1.57 format.
- Db  out  58  {fb, 5'b0}, 1.57 format.
- E  out  58  quotient approximation, 1.57 format.
- Eb  out  115  bits [114:0] of E·Db (2.114 format; bit 115 is always 0).
- db  out  1  registered db_in.

## Operation
- States: IDLE, SEED, MUL_T, MUL_X, MUL_Q, MUL_P, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: register Da, Db and db; clear the iteration counter; go to SEED.
- **SEED**
  - i = Db[56:49].
  - x0 = floor(2^16/(256+i)), 9-bit, 1.8 format. Range: i=0 gives 256 (1.0); i=255 gives 128 (0.5).
  - x = x0 << 49. Go to MUL_T.
  - The table is a constant ROM built at elaboration.
- **MUL_T**
  - t = (Db·x)[114:57].
- **MUL_X**
  - d = (2^58 − t)[57:0].
  - x = (x·d)[114:57].
  - Increment the counter. If the counter reaches (db ? ITER_D : ITER_S), go to MUL_Q; otherwise go to MUL_T.
- **MUL_Q**
  - E = (Da·x)[114:57].
- **MUL_P**
  - Eb = (E·Db)[114:0]. Go to DONE.
- **DONE**
  - out_valid=1.
  - On out_ready, go to IDLE.
- Arithmetic rules:
  - All products are unsigned 116-bit; truncation only, no rounding.
  - Quotient range: E < 2 because Da < 2 and x > 0.5.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0. Da, Db, E and Eb are all 0; db=0.
- Reset asserted mid-operation returns the block to IDLE in the same cycle (asynchronous) and discards the operation.
- in_ready is high only in IDLE; an input handshake takes one cycle, and no new operand is accepted until the output handshake completes.
- Latency, counted from the handshake edge to out_valid=1:
  - Double: 1 + 2·ITER_D + 2 = 9 cycles.
  - Single: 1 + 2·ITER_S + 2 = 7 cycles.
- E, Eb, Da, Db and db hold stable while out_valid=1 and out_ready=0; they are not cleared on leaving DONE.
- out_valid drops the cycle after out_valid & out_ready.
- in_ready rises in that same cycle, so back-to-back operations need a one-cycle IDLE gap.
- in_valid asserted while the block is busy is ignored; the source holds it until in_ready.

## Test plan
- **Unity, double.** fa=fb=2^52, db_in=1.
  - x0=256, and x stays at 2^57 through all iterations.
  - E=2^57; Eb has bit 114 set and all other bits 0.
  - out_valid at cycle 9.
- **Ratio 1.5, single.** fa=3·2^51, fb=2^52, db_in=0.
  - E=3·2^56.
  - out_valid at cycle 7.
- **Max divisor, double.** fa=2^52, fb=2^53−1, db_in=1.
  - Seed is 128.
  - |E − 2^57·Da/Db| ≤ 8 ulp.
  - Random sweep: 10k double and 10k single operand pairs.
    - Check against a 128-bit reference model: E error ≤ 8 ulp (double) and ≤ 2^30 ulp (single).
    - Check that Eb equals the truncated E·Db.
- **Backpressure.** Hold out_ready=0 for 5 cycles after out_valid.
  - Outputs stay constant and in_ready=0 throughout.
  - out_valid falls one cycle after out_ready=1.
- **Reset mid-op.** Pulse rst in MUL_X of iteration 2.
  - Outputs go to zero and state to IDLE immediately.
  - The next operation (fa=fb=2^52) completes correctly with 9-cycle latency.

Source files
------------

// File: rtl/nr_quotient_approx.sv
// ---------------------------------------------------------------------------
// nr_quotient_approx
//
// Sequential Newton-Raphson quotient approximator for the FPU divide path.
// The block takes two normalized significands and seeds a reciprocal of the
// divisor from a small table. It refines that reciprocal with Newton
// iterations, then forms the quotient approximation E = Da*x and the
// back-product Eb = E*Db. A single 58x58 multiplier is shared across all
// steps, and exactly one product is formed per cycle.
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   operands valid (fa, fb, db_in)
//   in_ready   high only while idle; the input handshake is in_valid&in_ready
//   fa         dividend significand, 1.52, hidden bit fa[52]=1
//   fb         divisor significand, 1.52, hidden bit fb[52]=1
//   db_in      1 = double precision, 0 = single precision
//   out_valid  results valid; held until out_ready
//   out_ready  consumer accepts results
//   Da         {fa,5'b0}, 1.57
//   Db         {fb,5'b0}, 1.57
//   E          quotient approximation, 1.57
//   Eb         E*Db bits [114:0], 2.114
//   db         registered db_in
// ---------------------------------------------------------------------------
module nr_quotient_approx #(
  parameter int ITER_D = 3,
  parameter int ITER_S = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [52:0]  fa,
  input  logic [52:0]  fb,
  input  logic         db_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [57:0]  Da,
  output logic [57:0]  Db,
  output logic [57:0]  E,
  output logic [114:0] Eb,
  output logic         db
);

  // Operand width (1.57) and the kept product width. Every product we use
  // needs bits [114:0] only, so the top bit of the 116-bit product is
  // dropped at the multiplier.
  localparam int DATA_W   = 58;
  localparam int FRAC_W   = 57;
  localparam int PROD_W   = 115;
  localparam int ITER_MAX = (ITER_D > ITER_S) ? ITER_D : ITER_S;
  localparam int CNT_W    = $clog2(ITER_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    MUL_T = 3'd2,
    MUL_X = 3'd3,
    MUL_Q = 3'd4,
    MUL_P = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    iter_lim;

  // Reciprocal estimate x and the intermediate t = Db*x (both 1.57)
  logic [DATA_W-1:0]   x;
  logic [DATA_W-1:0]   t;

  logic [DATA_W-1:0]   mul_a;
  logic [DATA_W-1:0]   mul_b;
  logic [PROD_W-1:0]   prod;

  logic [8:0]          seed_rom [256];
  logic [8:0]          seed;

  // Keep the 1.57 result of a 2.114 product: truncate, never round.
  function automatic logic [DATA_W-1:0] trunc_hi(input logic [PROD_W-1:0] p);
    return p[PROD_W-1:FRAC_W];
  endfunction

  // 2 - t in 1.57, modulo 2^58 (the carry out of bit 57 is discarded).
  function automatic logic [DATA_W-1:0] two_minus(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  // Seed table: x0 = floor(2^16 / (256 + i)) in 1.8, indexed by the eight
  // fraction bits of the divisor just below the hidden bit. i=0 gives 1.0,
  // i=255 gives 0.5; every entry fits in 9 bits.
  for (genvar g = 0; g < 256; g++) begin : g_seed
    localparam int SEED_VAL = 65536 / (256 + g);
    assign seed_rom[g] = 9'(SEED_VAL);
  end

  assign seed     = seed_rom[Db[56:49]];
  assign cnt_inc  = cnt + CNT_W'(1);
  assign iter_lim = db ? CNT_W'(ITER_D) : CNT_W'(ITER_S);

  // Shared multiplier: the operand pair depends on the step being executed.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_T: begin
        mul_a = Db;
        mul_b = x;
      end
      MUL_X: begin
        mul_a = x;
        mul_b = two_minus(t);
      end
      MUL_Q: begin
        mul_a = Da;
        mul_b = x;
      end
      MUL_P: begin
        mul_a = E;
        mul_b = Db;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign prod = PROD_W'(mul_a) * PROD_W'(mul_b);

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SEED;
      end
      SEED:  state_nxt = MUL_T;
      MUL_T: state_nxt = MUL_X;
      // The counter is compared post-increment so that exactly
      // ITER_D/ITER_S refinement steps are executed.
      MUL_X: state_nxt = (cnt_inc == iter_lim) ? MUL_Q : MUL_T;
      MUL_Q: state_nxt = MUL_P;
      MUL_P: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, iteration counter and the visible result registers. Results are
  // written only by their own step, so they hold through DONE and after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      Da    <= '0;
      Db    <= '0;
      db    <= 1'b0;
      E     <= '0;
      Eb    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            Da  <= {fa, 5'b0};
            Db  <= {fb, 5'b0};
            db  <= db_in;
            cnt <= '0;
          end
        end
        MUL_X:   cnt <= cnt_inc;
        MUL_Q:   E   <= trunc_hi(prod);
        MUL_P:   Eb  <= prod;
        default: ;
      endcase
    end
  end

  // Internal iteration datapath; always rewritten in SEED before any use,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    case (state)
      SEED:    x <= {seed, 49'b0};
      MUL_T:   t <= trunc_hi(prod);
      MUL_X:   x <= trunc_hi(prod);
      default: ;
    endcase
  end

endmodule
